// File: rtl/spi_ram_sp_if.sv
// Command/response bus between the SPI slave and the single-port RAM.
// The master side drives command words; the slave side returns read bytes.
interface spi_ram_sp_if #(
  parameter int ADDR_SIZE = 8
);
  logic [ADDR_SIZE+1:0] din;
  logic                 rx_valid;
  logic [7:0]           dout;
  logic                 tx_valid;

  modport master (output din, output rx_valid, input dout, input tx_valid);
  modport slave  (input din, input rx_valid, output dout, output tx_valid);
endinterface

// File: rtl/spi_ram_sp.sv
// Single-port RAM driven by SPI command words {opcode, payload}.
// Tracks independent write/read addresses, optional auto-increment, and a sticky error flag.
module spi_ram_sp #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_ram_sp_if.slave      bus,
  output logic             err,
  input  logic             clr_err
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] ADDR_MASK = ADDR_SIZE'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  logic [7:0] mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_addr_ok_q, wr_addr_ok_d;
  logic                 rd_addr_ok_q, rd_addr_ok_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;

  op_e                  op;
  logic [ADDR_SIZE-1:0] payload;
  logic                 addr_oor;
  logic                 mem_we;
  logic                 err_set;

  assign op       = op_e'(bus.din[ADDR_SIZE+1:ADDR_SIZE]);
  assign payload  = bus.din[ADDR_SIZE-1:0];
  // Any payload bit above the memory index range means the address is out of range
  assign addr_oor = (payload & ~ADDR_MASK) != '0;

  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_ok_d = wr_addr_ok_q;
    rd_addr_ok_d = rd_addr_ok_q;
    dout_d       = dout_q;
    tx_valid_d   = tx_valid_q;
    mem_we       = 1'b0;
    err_set      = 1'b0;

    if (bus.rx_valid) begin
      tx_valid_d = 1'b0;
      unique case (op)
        OP_WR_ADDR: begin
          wr_addr_d    = payload & ADDR_MASK;
          wr_addr_ok_d = 1'b1;
          err_set      = addr_oor;
        end
        OP_WR_DATA: begin
          if (wr_addr_ok_q) begin
            mem_we = 1'b1;
            if (AUTO_INC != 0) wr_addr_d = (wr_addr_q + ADDR_SIZE'(1)) & ADDR_MASK;
          end else begin
            err_set = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          rd_addr_d    = payload & ADDR_MASK;
          rd_addr_ok_d = 1'b1;
          err_set      = addr_oor;
        end
        OP_RD_DATA: begin
          if (rd_addr_ok_q) begin
            dout_d     = mem[rd_addr_q[IDX_W-1:0]];
            tx_valid_d = 1'b1;
            if (AUTO_INC != 0) rd_addr_d = (rd_addr_q + ADDR_SIZE'(1)) & ADDR_MASK;
            else               rd_addr_ok_d = 1'b0;
          end else begin
            err_set = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A new error in the same cycle as a clear request keeps the flag set
    if (err_set)      err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_addr_ok_q <= 1'b0;
      rd_addr_ok_q <= 1'b0;
      dout_q       <= '0;
      tx_valid_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_ok_q <= wr_addr_ok_d;
      rd_addr_ok_q <= rd_addr_ok_d;
      dout_q       <= dout_d;
      tx_valid_q   <= tx_valid_d;
      err_q        <= err_d;
    end
  end

  // The array has no reset so stored contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q[IDX_W-1:0]] <= bus.din[7:0];
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_spi_ram_sp.sv
// Directed bench for spi_ram_sp: three instances cover AUTO_INC=0, AUTO_INC=1
// and a 16-word memory for out-of-range addressing.
module tb_spi_ram_sp;

  logic clk;
  logic rst_n;

  logic [9:0] din_t  [3];
  logic       rxv_t  [3];
  logic       clr_t  [3];
  logic [7:0] dout_o [3];
  logic       txv_o  [3];
  logic       err_o  [3];

  int checks_total;
  int checks_passed;

  spi_ram_sp_if #(.ADDR_SIZE(8)) bus0 ();
  spi_ram_sp_if #(.ADDR_SIZE(8)) bus1 ();
  spi_ram_sp_if #(.ADDR_SIZE(8)) bus2 ();

  assign bus0.din = din_t[0];
  assign bus0.rx_valid = rxv_t[0];
  assign bus1.din = din_t[1];
  assign bus1.rx_valid = rxv_t[1];
  assign bus2.din = din_t[2];
  assign bus2.rx_valid = rxv_t[2];
  assign dout_o[0] = bus0.dout;
  assign dout_o[1] = bus1.dout;
  assign dout_o[2] = bus2.dout;
  assign txv_o[0] = bus0.tx_valid;
  assign txv_o[1] = bus1.tx_valid;
  assign txv_o[2] = bus2.tx_valid;

  spi_ram_sp #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u_ram0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .err(err_o[0]), .clr_err(clr_t[0]));
  spi_ram_sp #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u_ram1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .err(err_o[1]), .clr_err(clr_t[1]));
  spi_ram_sp #(.MEM_DEPTH(16), .ADDR_SIZE(8), .AUTO_INC(0)) u_ram2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .err(err_o[2]), .clr_err(clr_t[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  // Called at a negedge; holds the command for one cycle and returns at the next negedge
  task automatic applyStimulus(input int sel, input logic [9:0] word, input logic clr);
    din_t[sel] = word;
    rxv_t[sel] = 1'b1;
    clr_t[sel] = clr;
    @(negedge clk);
    rxv_t[sel] = 1'b0;
    clr_t[sel] = 1'b0;
  endtask

  task automatic pulseClear(input int sel);
    clr_t[sel] = 1'b1;
    @(negedge clk);
    clr_t[sel] = 1'b0;
  endtask

  task automatic resetAll();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_t[i] = '0;
      rxv_t[i] = 1'b0;
      clr_t[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset_txv", 8'(txv_o[0]), 8'h00);
    checkOutput("reset_dout", dout_o[0], 8'h00);
    checkOutput("reset_err", 8'(err_o[0]), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Pre-load address 0 so the suppressed write can be detected later
    applyStimulus(0, 10'h000, 1'b0);
    applyStimulus(0, 10'h177, 1'b0);
    checkOutput("preload_err", 8'(err_o[0]), 8'h00);
    resetAll();

    applyStimulus(0, 10'h155, 1'b0);
    checkOutput("noaddr_wr_err", 8'(err_o[0]), 8'h01);
    applyStimulus(0, 10'h300, 1'b0);
    checkOutput("noaddr_rd_txv", 8'(txv_o[0]), 8'h00);
    checkOutput("noaddr_rd_err", 8'(err_o[0]), 8'h01);
    pulseClear(0);
    checkOutput("clr_err", 8'(err_o[0]), 8'h00);
    applyStimulus(0, 10'h000, 1'b0);
    applyStimulus(0, 10'h200, 1'b0);
    applyStimulus(0, 10'h300, 1'b0);
    checkOutput("mem_unchanged_dout", dout_o[0], 8'h77);
    checkOutput("mem_unchanged_txv", 8'(txv_o[0]), 8'h01);

    applyStimulus(0, 10'h03C, 1'b0);
    applyStimulus(0, 10'h1A5, 1'b0);
    applyStimulus(0, 10'h23C, 1'b0);
    checkOutput("pre_read_txv", 8'(txv_o[0]), 8'h00);
    applyStimulus(0, 10'h300, 1'b0);
    checkOutput("wr_rd_txv", 8'(txv_o[0]), 8'h01);
    checkOutput("wr_rd_dout", dout_o[0], 8'hA5);
    checkOutput("wr_rd_err", 8'(err_o[0]), 8'h00);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_txv_%0d", i), 8'(txv_o[0]), 8'h01);
      checkOutput($sformatf("hold_dout_%0d", i), dout_o[0], 8'hA5);
    end
    applyStimulus(0, 10'h001, 1'b0);
    checkOutput("hold_release_txv", 8'(txv_o[0]), 8'h00);

    applyStimulus(0, 10'h23C, 1'b0);
    applyStimulus(0, 10'h300, 1'b0);
    checkOutput("reread1_txv", 8'(txv_o[0]), 8'h01);
    checkOutput("reread1_dout", dout_o[0], 8'hA5);
    applyStimulus(0, 10'h300, 1'b0);
    checkOutput("reread2_txv", 8'(txv_o[0]), 8'h00);
    checkOutput("reread2_err", 8'(err_o[0]), 8'h01);

    // AUTO_INC wrap on both address registers
    applyStimulus(1, 10'h0FF, 1'b0);
    applyStimulus(1, 10'h111, 1'b0);
    applyStimulus(1, 10'h122, 1'b0);
    applyStimulus(1, 10'h2FF, 1'b0);
    applyStimulus(1, 10'h300, 1'b0);
    checkOutput("inc_rd1_txv", 8'(txv_o[1]), 8'h01);
    checkOutput("inc_rd1_dout", dout_o[1], 8'h11);
    applyStimulus(1, 10'h300, 1'b0);
    checkOutput("inc_rd2_txv", 8'(txv_o[1]), 8'h01);
    checkOutput("inc_rd2_dout", dout_o[1], 8'h22);
    applyStimulus(1, 10'h200, 1'b0);
    applyStimulus(1, 10'h300, 1'b0);
    checkOutput("inc_mem00", dout_o[1], 8'h22);
    checkOutput("inc_err", 8'(err_o[1]), 8'h00);

    // 16-word memory: out-of-range addresses wrap modulo depth and flag err
    applyStimulus(2, 10'h013, 1'b0);
    checkOutput("oor_wr_err", 8'(err_o[2]), 8'h01);
    applyStimulus(2, 10'h15A, 1'b0);
    pulseClear(2);
    checkOutput("oor_clr", 8'(err_o[2]), 8'h00);
    applyStimulus(2, 10'h203, 1'b0);
    applyStimulus(2, 10'h300, 1'b0);
    checkOutput("oor_wrap_dout", dout_o[2], 8'h5A);
    checkOutput("oor_inrange_err", 8'(err_o[2]), 8'h00);
    applyStimulus(2, 10'h014, 1'b1);
    checkOutput("set_wins_err", 8'(err_o[2]), 8'h01);
    pulseClear(2);
    applyStimulus(2, 10'h2F3, 1'b0);
    checkOutput("oor_rd_err", 8'(err_o[2]), 8'h01);
    applyStimulus(2, 10'h300, 1'b0);
    checkOutput("oor_rd_dout", dout_o[2], 8'h5A);

    // err is still set from the failed re-read; reset must clear it along with the read
    applyStimulus(0, 10'h23C, 1'b0);
    applyStimulus(0, 10'h300, 1'b0);
    checkOutput("pre_rst_txv", 8'(txv_o[0]), 8'h01);
    checkOutput("pre_rst_err", 8'(err_o[0]), 8'h01);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_txv", 8'(txv_o[0]), 8'h00);
    checkOutput("midrst_dout", dout_o[0], 8'h00);
    checkOutput("midrst_err", 8'(err_o[0]), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 10'h23C, 1'b0);
    applyStimulus(0, 10'h300, 1'b0);
    checkOutput("post_rst_3c", dout_o[0], 8'hA5);
    applyStimulus(0, 10'h200, 1'b0);
    applyStimulus(0, 10'h300, 1'b0);
    checkOutput("post_rst_00", dout_o[0], 8'h77);
    checkOutput("post_rst_txv", 8'(txv_o[0]), 8'h01);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/spi_ram_sp.md
Name: spi_ram_sp

Overview:
- Single-port synchronous RAM that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid command words and executes the encoded operation:
  - write address
  - write data
  - read address
  - read data
- Returns read bytes to the slave on tx_data/tx_valid for MISO serialisation.
- Adds an address-sequence checker, optional address auto-increment and a sticky protocol-error flag.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; must be a power of two no greater than 2**ADDR_SIZE.
- ADDR_SIZE, 8, address width; equals the data field width of the command word.
- AUTO_INC, 0, 1 = write address post-increments after each write-data and read address post-increments after each read-data, both modulo MEM_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  10  command word from SPI slave: din[9:8] opcode, din[7:0] payload.
- rx_valid  in  1  single-cycle strobe, din valid.
- dout  out  8  read data to SPI slave (tx_data).
- tx_valid  out  1  dout valid; held until consumed (see below).
- err  out  1  sticky protocol error.
- clr_err  in  1  synchronous clear of err.

Behaviour:
- Reset (asynchronous, rst_n low): dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0, wr_addr_ok=0, rd_addr_ok=0.
  - Memory array is not cleared.
  - Reset mid-operation aborts any pending read; tx_valid drops immediately.
- All commands are sampled only when rx_valid=1. With rx_valid=0, no state changes except clr_err.
- Opcode 00, write address: wr_addr <= din[ADDR_SIZE-1:0]; wr_addr_ok <= 1.
- Opcode 01, write data:
  - If wr_addr_ok: mem[wr_addr] <= din[7:0] at this edge.
  - If AUTO_INC: wr_addr <= wr_addr+1, wrapping from MEM_DEPTH-1 to 0.
  - If !wr_addr_ok: write is suppressed and err <= 1.
- Opcode 10, read address: rd_addr <= din[ADDR_SIZE-1:0]; rd_addr_ok <= 1.
- Opcode 11, read data:
  - If rd_addr_ok: at this edge dout <= mem[rd_addr] and tx_valid <= 1, giving a one-cycle latency from the rx_valid edge to tx_valid.
  - If AUTO_INC: rd_addr increments with wrap. If AUTO_INC=0: rd_addr_ok <= 0, so each read needs a fresh read address.
  - If !rd_addr_ok: dout unchanged, tx_valid stays 0, err <= 1.
  - din[7:0] is don't-care.
- tx_valid hold rule:
  - Once set, tx_valid and dout stay stable until the next rx_valid of any opcode.
  - At that edge tx_valid clears, unless the command is itself a valid read-data, in which case tx_valid stays 1 with the new dout.
- Address out of range (payload >= MEM_DEPTH when MEM_DEPTH < 2**ADDR_SIZE): address is latched modulo MEM_DEPTH and err <= 1.
- err:
  - Set by any of the error conditions above.
  - Cleared by clr_err=1 at a clock edge.
  - If an error condition and clr_err=1 coincide, set wins.
- Write and read address registers are independent; a write never disturbs rd_addr or dout.
- Same-address write then read returns the new data (write happens at the 01 edge, before any later 11 edge).

Test Plan:
- Write then read: reset; send 00_0x3C, 01_0xA5, 10_0x3C, 11_0x00. Required: tx_valid=1 exactly one cycle after the 11 strobe with dout=0xA5; err=0.
- tx_valid hold: after the previous read, idle 20 cycles. Required: tx_valid=1 and dout=0xA5 throughout. Then send 00_0x01. Required: tx_valid=0 the following cycle.
- Missing address:
  - After reset send 01_0x55. Required: err=1, memory unchanged; a later 00_0x00 / 10_0x00 / 11 sequence reads the pre-written value, not 0x55.
  - Send 11 with no read address. Required: tx_valid stays 0, err=1.
  - Pulse clr_err. Required: err=0.
- AUTO_INC=1 wrap, MEM_DEPTH=256:
  - Send 00_0xFF, 01_0x11, 01_0x22. Required: mem[0xFF]=0x11, mem[0x00]=0x22.
  - Then send 10_0xFF, 11, 11. Required: dout 0x11 then 0x22, tx_valid continuously high.
- AUTO_INC=0 re-read: send 10_0x3C, 11, 11. Required: first read gives valid data; second read gives err=1, tx_valid=0 after the second strobe.
- Reset mid-read: assert rst_n low asynchronously, between clock edges, while tx_valid=1. Required: tx_valid=0, dout=0, err=0 immediately. After release, previously written memory contents are still readable.
